// File: rtl/idma_burst_sched_if.sv
`default_nettype none
// ============================================================================
// Module  : idma_burst_sched_if
// Brief   : Command and burst handshake bundle for idma_burst_sched.
// Revision: 1.0
// ============================================================================
interface idma_burst_sched_if;
  logic [1:0]  cmd_valid;
  logic [1:0]  cmd_ready;
  logic [63:0] cmd_addr;
  logic [31:0] cmd_beats;
  logic        burst_avalid;
  logic [31:0] burst_addr;
  logic [3:0]  burst_len;
  logic        burst_ch;
  logic        burst_ok;
  logic        xdata_ok;
  logic [1:0]  done;

  modport master (
    output cmd_valid, cmd_addr, cmd_beats, burst_ok, xdata_ok,
    input  cmd_ready, burst_avalid, burst_addr, burst_len, burst_ch, done
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_beats, burst_ok, xdata_ok,
    output cmd_ready, burst_avalid, burst_addr, burst_len, burst_ch, done
  );
endinterface
`default_nettype wire

// File: rtl/idma_burst_sched.sv
`default_nettype none
// ============================================================================
// Module  : idma_burst_sched
// Brief   : Two-channel DMA command splitter issuing round-robin AXI bursts.
// Revision: 1.0
// ============================================================================
module idma_burst_sched #(
  parameter int MAX_OST = 4
) (
  input  wire logic         aclk,
  input  wire logic         aresetn,
  idma_burst_sched_if.slave bus
);
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  state_t      r_state [2];
  logic [31:0] r_addr  [2];
  logic [15:0] r_rem   [2];
  logic        r_rr_ptr;
  logic [3:0]  r_inflight;
  logic [2:0]  r_wr_ptr;
  logic [2:0]  r_rd_ptr;
  logic        r_fifo_ch   [8];
  logic        r_fifo_last [8];
  logic        r_avalid;
  logic [31:0] r_baddr;
  logic [3:0]  r_blen;
  logic        r_bch;
  logic [1:0]  r_done;

  logic [1:0]  w_active;
  logic        w_gnt;
  logic [15:0] w_rem;
  logic        w_last;
  logic [4:0]  w_beats;
  logic        w_load;
  logic        w_pop;
  logic        w_pop_ch;
  logic        w_pop_last;
  logic [2:0]  w_wr_nxt;
  logic [2:0]  w_rd_nxt;

  always_comb begin
    w_active   = {r_state[1] == ST_ACTIVE, r_state[0] == ST_ACTIVE};
    // r_rr_ptr names the channel holding priority for the next grant
    w_gnt      = w_active[r_rr_ptr] ? r_rr_ptr : ~r_rr_ptr;
    w_rem      = r_rem[w_gnt];
    w_last     = (w_rem <= 16'd16);
    w_beats    = w_last ? w_rem[4:0] : 5'd16;
    w_load     = (!r_avalid || bus.burst_ok) && (|w_active) &&
                 (r_inflight < 4'(MAX_OST));
    w_pop      = bus.xdata_ok && (r_inflight != 4'd0);
    w_pop_ch   = r_fifo_ch[r_rd_ptr];
    w_pop_last = r_fifo_last[r_rd_ptr];
    w_wr_nxt   = (r_wr_ptr == 3'(MAX_OST - 1)) ? 3'd0 : r_wr_ptr + 3'd1;
    w_rd_nxt   = (r_rd_ptr == 3'(MAX_OST - 1)) ? 3'd0 : r_rd_ptr + 3'd1;
  end

  // Ordering FIFO payload; occupancy is tracked by r_inflight
  always_ff @(posedge aclk) begin
    if (w_load) begin
      r_fifo_ch[r_wr_ptr]   <= w_gnt;
      r_fifo_last[r_wr_ptr] <= w_last;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int n = 0; n < 2; n++) begin
        r_state[n] <= ST_IDLE;
        r_addr[n]  <= '0;
        r_rem[n]   <= '0;
      end
      r_rr_ptr   <= 1'b0;
      r_inflight <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_avalid   <= 1'b0;
      r_baddr    <= '0;
      r_blen     <= '0;
      r_bch      <= 1'b0;
      r_done     <= '0;
    end else begin
      r_done <= 2'b00;
      for (int n = 0; n < 2; n++) begin
        case (r_state[n])
          ST_IDLE: begin
            if (bus.cmd_valid[n]) begin
              r_addr[n] <= bus.cmd_addr[32*n +: 32] & 32'hFFFF_FFE0;
              r_rem[n]  <= bus.cmd_beats[16*n +: 16];
              // Empty command: complete immediately, one DRAIN cycle follows
              if (bus.cmd_beats[16*n +: 16] == 16'd0) begin
                r_state[n] <= ST_DRAIN;
                r_done[n]  <= 1'b1;
              end else begin
                r_state[n] <= ST_ACTIVE;
              end
            end
          end
          ST_ACTIVE: begin
            if (w_load && (w_gnt == 1'(n))) begin
              r_addr[n] <= r_addr[n] + {22'd0, w_beats, 5'd0};
              r_rem[n]  <= r_rem[n] - {11'd0, w_beats};
              if (w_last) r_state[n] <= ST_DRAIN;
            end
          end
          ST_DRAIN: begin
            if (r_done[n]) begin
              r_state[n] <= ST_IDLE;
            end else if (w_pop && w_pop_last && (w_pop_ch == 1'(n))) begin
              r_state[n] <= ST_IDLE;
              r_done[n]  <= 1'b1;
            end
          end
          default: r_state[n] <= ST_IDLE;
        endcase
      end

      if (w_load) begin
        r_avalid <= 1'b1;
        r_baddr  <= r_addr[w_gnt];
        r_blen   <= 4'(w_beats - 5'd1);
        r_bch    <= w_gnt;
        r_rr_ptr <= ~w_gnt;
        r_wr_ptr <= w_wr_nxt;
      end else if (bus.burst_ok) begin
        r_avalid <= 1'b0;
      end

      if (w_pop) r_rd_ptr <= w_rd_nxt;
      if (w_load && !w_pop)      r_inflight <= r_inflight + 4'd1;
      else if (!w_load && w_pop) r_inflight <= r_inflight - 4'd1;
    end
  end

  assign bus.cmd_ready    = {r_state[1] == ST_IDLE, r_state[0] == ST_IDLE};
  assign bus.burst_avalid = r_avalid;
  assign bus.burst_addr   = r_baddr;
  assign bus.burst_len    = r_blen;
  assign bus.burst_ch     = r_bch;
  assign bus.done         = r_done;
endmodule
`default_nettype wire

// File: tb/tb_idma_burst_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_idma_burst_sched
// Brief   : Self-checking bench: directed scenarios plus randomized scoreboard.
// Revision: 1.0
// ============================================================================
module tb_idma_burst_sched;
  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  len;
    logic        last;
  } burst_t;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  burst_t q0[$];
  burst_t q1[$];

  idma_burst_sched_if bus();

  idma_burst_sched #(.MAX_OST(4)) u_dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus.slave)
  );

  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    bus.cmd_valid = '0;
    bus.burst_ok  = 1'b0;
    bus.xdata_ok  = 1'b0;
    aresetn       = 1'b0;
    repeat (2) tick();
    aresetn = 1'b1;
    tick();
  endtask

  // Reference split of one command into its expected burst list
  task automatic plan(input int ch, input logic [31:0] a, input int beats);
    logic [31:0] ad = a & 32'hFFFF_FFE0;
    int rem = beats;
    burst_t b;
    while (rem > 0) begin
      int nb = (rem > 16) ? 16 : rem;
      b.addr = ad;
      b.len  = 4'(nb - 1);
      b.last = (rem == nb);
      if (ch == 0) q0.push_back(b); else q1.push_back(b);
      ad  = ad + 32'(nb * 32);
      rem = rem - nb;
    end
  endtask

  task automatic test_reset();
    bus.cmd_valid = '0; bus.burst_ok = 1'b0; bus.xdata_ok = 1'b0;
    aresetn = 1'b0;
    repeat (2) tick();
    n_vec++;
    if ({bus.burst_avalid, bus.burst_addr, bus.burst_len, bus.burst_ch, bus.done} !== '0)
      begin n_err++; $display("FAIL reset_outputs: got av=%b addr=%h len=%0d ch=%b done=%b, want all 0",
        bus.burst_avalid, bus.burst_addr, bus.burst_len, bus.burst_ch, bus.done); end
    n_vec++;
    if (bus.cmd_ready !== 2'b11) begin n_err++;
      $display("FAIL reset_ready: got %b want 11", bus.cmd_ready); end
    aresetn = 1'b1;
    tick();
    n_vec++;
    if (bus.cmd_ready !== 2'b11) begin n_err++;
      $display("FAIL post_reset_ready: got %b want 11", bus.cmd_ready); end
  endtask

  task automatic test_single();
    logic [31:0] ea [3] = '{32'h1000, 32'h1200, 32'h1400};
    logic [3:0]  el [3] = '{4'd15, 4'd15, 4'd7};
    int k = 0, dn = 0;
    logic acc = 1'b0;
    do_reset();
    bus.cmd_addr[31:0] = 32'h1000; bus.cmd_beats[15:0] = 16'd40;
    bus.cmd_valid = 2'b01; bus.burst_ok = 1'b1;
    tick();
    bus.cmd_valid = 2'b00;
    for (int c = 0; c < 40; c++) begin
      bus.xdata_ok = acc;
      acc = bus.burst_avalid;
      if (bus.burst_avalid) begin
        n_vec++;
        if (k >= 3) begin n_err++; $display("FAIL single_extra: burst %0d addr=%h, want none", k, bus.burst_addr); end
        else if (bus.burst_addr !== ea[k] || bus.burst_len !== el[k] || bus.burst_ch !== 1'b0) begin
          n_err++; $display("FAIL single_burst%0d: got addr=%h len=%0d ch=%b want addr=%h len=%0d ch=0",
            k, bus.burst_addr, bus.burst_len, bus.burst_ch, ea[k], el[k]); end
        k++;
      end
      tick();
      if (bus.done[0]) dn++;
      n_vec++;
      if (bus.done[1] !== 1'b0) begin n_err++; $display("FAIL single_done1: got 1 want 0"); end
    end
    bus.burst_ok = 1'b0; bus.xdata_ok = 1'b0;
    n_vec++;
    if (k != 3) begin n_err++; $display("FAIL single_count: got %0d bursts want 3", k); end
    n_vec++;
    if (dn != 1) begin n_err++; $display("FAIL single_done: got %0d done cycles want 1", dn); end
  endtask

  task automatic test_two_ch();
    logic [31:0] ea [4] = '{32'h0, 32'h8000, 32'h200, 32'h8200};
    logic [3:0]  el [4] = '{4'd15, 4'd15, 4'd3, 4'd3};
    logic        ec [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    int k = 0, dc0 = -1, dc1 = -1, dn = 0;
    logic acc = 1'b0;
    logic [1:0] pdone = 2'b00;
    do_reset();
    bus.cmd_addr = {32'h8000, 32'h0}; bus.cmd_beats = {16'd20, 16'd20};
    bus.cmd_valid = 2'b11; bus.burst_ok = 1'b1;
    tick();
    bus.cmd_valid = 2'b00;
    for (int c = 0; c < 40; c++) begin
      bus.xdata_ok = acc;
      acc = bus.burst_avalid;
      if (bus.burst_avalid) begin
        n_vec++;
        if (k >= 4) begin n_err++; $display("FAIL two_extra: burst %0d ch=%b, want none", k, bus.burst_ch); end
        else if (bus.burst_addr !== ea[k] || bus.burst_len !== el[k] || bus.burst_ch !== ec[k]) begin
          n_err++; $display("FAIL two_burst%0d: got addr=%h len=%0d ch=%b want addr=%h len=%0d ch=%b",
            k, bus.burst_addr, bus.burst_len, bus.burst_ch, ea[k], el[k], ec[k]); end
        k++;
      end
      tick();
      for (int n = 0; n < 2; n++) if (pdone[n]) begin
        n_vec++;
        if (bus.cmd_ready[n] !== 1'b1) begin n_err++;
          $display("FAIL two_ready_after_done%0d: got 0 want 1", n); end
      end
      if (bus.done[0]) begin dc0 = c; dn++; end
      if (bus.done[1]) begin dc1 = c; dn++; end
      pdone = bus.done;
    end
    bus.burst_ok = 1'b0; bus.xdata_ok = 1'b0;
    n_vec++;
    if (k != 4 || dn != 2) begin n_err++; $display("FAIL two_count: got %0d bursts %0d dones want 4 and 2", k, dn); end
    n_vec++;
    if (dc0 < 0 || dc1 != dc0 + 1) begin n_err++;
      $display("FAIL two_consecutive: got done0@%0d done1@%0d want adjacent", dc0, dc1); end
  endtask

  task automatic test_ost();
    int acc = 0;
    logic seen = 1'b0;
    do_reset();
    bus.cmd_addr[31:0] = 32'h0; bus.cmd_beats[15:0] = 16'd160;
    bus.cmd_valid = 2'b01; bus.burst_ok = 1'b1;
    tick();
    bus.cmd_valid = 2'b00;
    for (int c = 0; c < 20; c++) begin
      if (bus.burst_avalid) acc++;
      tick();
    end
    n_vec++;
    if (acc != 4) begin n_err++; $display("FAIL ost_count: got %0d accepted want 4", acc); end
    n_vec++;
    if (bus.burst_avalid !== 1'b0) begin n_err++; $display("FAIL ost_stall: avalid got 1 want 0"); end
    bus.xdata_ok = 1'b1;
    tick();
    bus.xdata_ok = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (bus.burst_avalid) seen = 1'b1;
      tick();
    end
    n_vec++;
    if (!seen) begin n_err++; $display("FAIL ost_resume: avalid got 0 want 1 after xdata_ok"); end
    bus.burst_ok = 1'b0;
  endtask

  task automatic test_zero();
    do_reset();
    bus.cmd_addr[63:32] = 32'h23; bus.cmd_beats[31:16] = 16'd0;
    bus.cmd_valid = 2'b10;
    tick();
    bus.cmd_valid = 2'b00;
    n_vec++;
    if (bus.done !== 2'b10 || bus.burst_avalid !== 1'b0) begin n_err++;
      $display("FAIL zero_done: got done=%b av=%b want done=10 av=0", bus.done, bus.burst_avalid); end
    tick();
    n_vec++;
    if (bus.done !== 2'b00 || bus.cmd_ready[1] !== 1'b1 || bus.burst_avalid !== 1'b0) begin n_err++;
      $display("FAIL zero_after: got done=%b rdy1=%b av=%b want 00 1 0", bus.done, bus.cmd_ready[1], bus.burst_avalid); end
    repeat (3) tick();
    n_vec++;
    if (bus.burst_avalid !== 1'b0) begin n_err++; $display("FAIL zero_noburst: avalid got 1 want 0"); end
  endtask

  task automatic test_hold();
    logic [31:0] sa;
    logic [3:0]  sl;
    logic        sc;
    do_reset();
    bus.cmd_addr[31:0] = 32'h3000; bus.cmd_beats[15:0] = 16'd40;
    bus.cmd_valid = 2'b01; bus.burst_ok = 1'b0;
    tick();
    bus.cmd_valid = 2'b00;
    for (int c = 0; c < 5 && !bus.burst_avalid; c++) tick();
    n_vec++;
    if (bus.burst_avalid !== 1'b1) begin n_err++; $display("FAIL hold_start: avalid got 0 want 1"); end
    sa = bus.burst_addr; sl = bus.burst_len; sc = bus.burst_ch;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_vec++;
      if (bus.burst_avalid !== 1'b1 || bus.burst_addr !== sa || bus.burst_len !== sl || bus.burst_ch !== sc) begin
        n_err++; $display("FAIL hold_stable: got av=%b addr=%h len=%0d ch=%b want 1 %h %0d %b",
          bus.burst_avalid, bus.burst_addr, bus.burst_len, bus.burst_ch, sa, sl, sc); end
    end
    bus.burst_ok = 1'b1;
    tick();
    bus.burst_ok = 1'b0;
    n_vec++;
    if (bus.burst_avalid !== 1'b1 || bus.burst_addr !== 32'h3200) begin n_err++;
      $display("FAIL hold_b2b: got av=%b addr=%h want 1 00003200", bus.burst_avalid, bus.burst_addr); end
  endtask

  task automatic test_reset_mid();
    int acc = 0, nb = 0, dn = 0;
    logic a2 = 1'b0;
    do_reset();
    bus.cmd_addr[31:0] = 32'h0; bus.cmd_beats[15:0] = 16'd160;
    bus.cmd_valid = 2'b01; bus.burst_ok = 1'b1;
    tick();
    bus.cmd_valid = 2'b00;
    for (int c = 0; c < 20 && acc < 2; c++) begin
      if (bus.burst_avalid) acc++;
      tick();
    end
    bus.burst_ok = 1'b0;
    aresetn = 1'b0;
    #1;
    n_vec++;
    if ({bus.burst_avalid, bus.burst_addr, bus.burst_len, bus.burst_ch, bus.done} !== '0 || bus.cmd_ready !== 2'b11) begin
      n_err++; $display("FAIL midrst_clear: got av=%b addr=%h len=%0d ch=%b done=%b rdy=%b want zeros rdy=11",
        bus.burst_avalid, bus.burst_addr, bus.burst_len, bus.burst_ch, bus.done, bus.cmd_ready); end
    for (int c = 0; c < 2; c++) begin
      tick();
      n_vec++;
      if (bus.done !== 2'b00) begin n_err++; $display("FAIL midrst_done: got %b want 00", bus.done); end
    end
    aresetn = 1'b1;
    tick();
    bus.cmd_addr[31:0] = 32'h40; bus.cmd_beats[15:0] = 16'd4;
    bus.cmd_valid = 2'b01; bus.burst_ok = 1'b1;
    tick();
    bus.cmd_valid = 2'b00;
    for (int c = 0; c < 12; c++) begin
      bus.xdata_ok = a2;
      a2 = bus.burst_avalid;
      if (bus.burst_avalid) begin
        nb++;
        n_vec++;
        if (bus.burst_addr !== 32'h40 || bus.burst_len !== 4'd3 || bus.burst_ch !== 1'b0) begin n_err++;
          $display("FAIL midrst_fresh: got addr=%h len=%0d ch=%b want 00000040 3 0", bus.burst_addr, bus.burst_len, bus.burst_ch); end
      end
      tick();
      if (bus.done[0]) dn++;
    end
    bus.burst_ok = 1'b0; bus.xdata_ok = 1'b0;
    n_vec++;
    if (nb != 1 || dn != 1) begin n_err++; $display("FAIL midrst_count: got %0d bursts %0d dones want 1 1", nb, dn); end
  endtask

  task automatic test_random();
    logic [1:0]  busy = 2'b00, exp_done, pre_vld, pre_rdy;
    logic        pre_av, pre_ok, pre_xd, pre_ch;
    logic [31:0] pre_addr;
    logic [3:0]  pre_len;
    logic [31:0] pre_ca [2];
    int          pre_cb [2];
    logic [1:0]  outq[$];
    logic [1:0]  ent;
    burst_t      e;
    logic        got;
    q0.delete(); q1.delete();
    do_reset();
    for (int c = 0; c < 6000; c++) begin
      if (c >= 3000 && busy == 2'b00 && bus.cmd_valid == 2'b00) break;
      for (int n = 0; n < 2; n++)
        if (c < 3000 && !busy[n] && !bus.cmd_valid[n] && $urandom_range(0, 3) == 0) begin
          bus.cmd_addr[32*n +: 32] = $urandom;
          bus.cmd_beats[16*n +: 16] = 16'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 200) : $urandom_range(0, 40));
          bus.cmd_valid[n] = 1'b1;
        end
      bus.burst_ok = (c >= 3000) || ($urandom_range(0, 2) != 0);
      bus.xdata_ok = (outq.size() > 0) && ((c >= 3000) || ($urandom_range(0, 1) == 1));
      pre_av = bus.burst_avalid; pre_ok = bus.burst_ok; pre_xd = bus.xdata_ok;
      pre_addr = bus.burst_addr; pre_len = bus.burst_len; pre_ch = bus.burst_ch;
      pre_vld = bus.cmd_valid; pre_rdy = bus.cmd_ready;
      for (int n = 0; n < 2; n++) begin
        pre_ca[n] = bus.cmd_addr[32*n +: 32];
        pre_cb[n] = int'(bus.cmd_beats[16*n +: 16]);
      end
      tick();
      exp_done = 2'b00;
      if (pre_av && pre_ok) begin
        got = 1'b0;
        if (pre_ch == 1'b0 && q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
        if (pre_ch == 1'b1 && q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
        n_vec++;
        if (!got || pre_addr !== e.addr || pre_len !== e.len) begin n_err++;
          $display("FAIL rnd_burst: got ch=%b addr=%h len=%0d want addr=%h len=%0d (expected=%b)",
            pre_ch, pre_addr, pre_len, e.addr, e.len, got); end
        if (got) outq.push_back({pre_ch, e.last});
      end
      if (pre_av && !pre_ok) begin
        n_vec++;
        if (bus.burst_avalid !== 1'b1 || bus.burst_addr !== pre_addr || bus.burst_len !== pre_len || bus.burst_ch !== pre_ch) begin
          n_err++; $display("FAIL rnd_hold: got av=%b addr=%h len=%0d ch=%b want 1 %h %0d %b",
            bus.burst_avalid, bus.burst_addr, bus.burst_len, bus.burst_ch, pre_addr, pre_len, pre_ch); end
      end
      if (pre_xd) begin
        ent = outq.pop_front();
        if (ent[0]) exp_done[ent[1]] = 1'b1;
      end
      for (int n = 0; n < 2; n++)
        if (pre_vld[n] && pre_rdy[n]) begin
          plan(n, pre_ca[n], pre_cb[n]);
          busy[n] = 1'b1;
          if (pre_cb[n] == 0) exp_done[n] = 1'b1;
          bus.cmd_valid[n] = 1'b0;
        end
      n_vec++;
      if (bus.done !== exp_done) begin n_err++;
        $display("FAIL rnd_done: cycle %0d got %b want %b", c, bus.done, exp_done); end
      busy = busy & ~exp_done;
      n_vec++;
      if ((bus.cmd_ready & busy) != 2'b00) begin n_err++;
        $display("FAIL rnd_ready: cycle %0d got ready=%b while busy=%b", c, bus.cmd_ready, busy); end
      n_vec++;
      if (outq.size() + int'(bus.burst_avalid) > 4) begin n_err++;
        $display("FAIL rnd_ost: got %0d in flight want <= 4", outq.size() + int'(bus.burst_avalid)); end
    end
    bus.burst_ok = 1'b0; bus.xdata_ok = 1'b0; bus.cmd_valid = 2'b00;
    n_vec++;
    if (busy != 2'b00 || q0.size() != 0 || q1.size() != 0 || outq.size() != 0) begin n_err++;
      $display("FAIL rnd_drain: busy=%b left q0=%0d q1=%0d outq=%0d want all 0",
        busy, q0.size(), q1.size(), outq.size()); end
  endtask

  initial begin
    bus.cmd_valid = '0;
    bus.cmd_addr  = '0;
    bus.cmd_beats = '0;
    bus.burst_ok  = 1'b0;
    bus.xdata_ok  = 1'b0;
    test_reset();
    test_single();
    test_two_ch();
    test_ost();
    test_zero();
    test_hold();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/idma_burst_sched.md
IDMA_BURST_SCHED -- requirements
Module: idma_burst_sched

Interface
REQ-001 SHALL have parameter MAX_OST, default 4 (range 1..8): maximum bursts in flight.
REQ-002 SHALL have input aclk, 1 bit: clock; all state changes on its rising edge.
REQ-003 SHALL have input aresetn, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have input cmd_valid, 2 bits: per-channel command request; bit n is channel n.
REQ-005 SHALL have output cmd_ready, 2 bits: channel n can accept a command.
REQ-006 SHALL have input cmd_addr, 64 bits: channel n start byte address in [32n+31:32n].
REQ-007 SHALL have input cmd_beats, 32 bits: channel n total 32-byte beats in [16n+15:16n].
REQ-008 SHALL have output burst_avalid, 1 bit: burst request to the address splitter.
REQ-009 SHALL have output burst_addr, 32 bits: burst start byte address.
REQ-010 SHALL have output burst_len, 4 bits: AXI len, which is beats minus 1.
REQ-011 SHALL have output burst_ch, 1 bit: owning channel of the presented burst.
REQ-012 SHALL have input burst_ok, 1 bit: splitter accepted the presented burst (final address phase done).
REQ-013 SHALL have input xdata_ok, 1 bit: data phase of the oldest in-flight burst completed.
REQ-014 SHALL have output done, 2 bits: single-cycle pulse when channel n's command has fully completed.

Function
REQ-015 Each channel SHALL run FSM IDLE -> ACTIVE -> DRAIN -> IDLE.
- cmd_ready[n] = (state == IDLE).
REQ-016 Command handshake (cmd_valid & cmd_ready) SHALL latch the channel's parameters.
- Address latched with bits [4:0] forced to 0.
- remaining = cmd_beats.
- Next state ACTIVE, or DRAIN if cmd_beats == 0.
REQ-017 Burst size SHALL be beats = min(remaining, 16); burst_len = beats - 1, truncated to 4 bits.
REQ-018 After each burst load, the channel address SHALL advance by beats*32 with 32-bit wrap, and remaining SHALL decrease by beats.
- When remaining reaches 0, the state becomes DRAIN.
REQ-019 The output burst register SHALL be loaded when all three hold:
- no burst is held, or burst_ok is asserted this cycle;
- at least one channel is ACTIVE;
- inflight < MAX_OST.
REQ-020 Arbitration SHALL be round-robin per burst.
- The last-granted channel has lowest priority.
- After reset, channel 0 has priority.
REQ-021 burst_avalid SHALL be registered.
- Earliest assertion is the cycle after a command handshake.
- It stays high back-to-back when a reload happens in the same cycle as burst_ok.
REQ-022 burst_addr, burst_len and burst_ch SHALL be held stable while burst_avalid=1 and burst_ok=0.
REQ-023 inflight SHALL increment on a load and decrement on xdata_ok.
- A simultaneous load and xdata_ok leave it unchanged.
- xdata_ok with inflight == 0 SHALL be ignored.
REQ-024 Each load SHALL push {ch, last} into a MAX_OST-deep in-order FIFO; last=1 for a channel's final burst.
- Each xdata_ok SHALL pop the FIFO.
- A popped entry with last=1 SHALL pulse done[ch] in the next cycle.
- The channel returns to IDLE in that same cycle.
REQ-025 A zero-beat command SHALL issue no burst and pulse done in the cycle after the handshake.
REQ-026 Both channels SHALL be able to complete in consecutive cycles.
- The same channel SHALL be able to accept a new command in the cycle after its done pulse.
REQ-027 burst_ok while burst_avalid=0 SHALL be ignored.

Reset
REQ-028 On aresetn low the block SHALL asynchronously clear:
- all channel states to IDLE;
- inflight to 0 and the FIFO to empty;
- burst_avalid, burst_addr, burst_len, burst_ch and done to 0;
- round-robin pointer to channel 0.
- cmd_ready SHALL be 2'b11 while reset is asserted.
REQ-029 Reset asserted mid-operation SHALL discard all commands and in-flight bookkeeping without emitting done.

Verification
REQ-030 ch0 addr=0x1000, beats=40, burst_ok tied 1, xdata_ok 1 cycle after each burst_ok -> bursts (0x1000,len 15), (0x1200,len 15), (0x1400,len 7), then one done[0] pulse.
REQ-031 ch0 beats=20 @0x0, ch1 beats=20 @0x8000, both given in the same cycle -> burst_ch sequence 0,1,0,1 with lens 15,15,3,3.
REQ-032 MAX_OST=4, xdata_ok held 0, ch0 beats=160 -> exactly 4 bursts accepted, then burst_avalid=0 until one xdata_ok.
REQ-033 ch1 addr=0x23, beats=0 -> no burst_avalid; done[1] pulses the cycle after the handshake; cmd_ready[1] is 1 on the following cycle.
REQ-034 burst_ok held 0 for 5 cycles with avalid=1 -> addr/len/ch unchanged throughout.
REQ-035 aresetn pulsed low mid-transfer with inflight=3 -> all outputs 0, cmd_ready=2'b11, no done, and a fresh command proceeds normally.
